sgpio_initiator: RTL and testbench

//  SGPIO initiator (SFF-8485 style): the transmit end of the SGPIO links the Status CPLD receives on.

---
 rtl/sgpio_initiator_pkg.sv | 9 +
 rtl/sgpio_initiator_if.sv | 13 +
 rtl/sgpio_initiator_clk_gen.sv | 31 +++
 rtl/sgpio_initiator.sv | 78 +++++++
 tb/tb_sgpio_initiator.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/sgpio_initiator_pkg.sv
// sgpio_initiator_pkg: shared SGPIO frame constants and initiator FSM state type
package sgpio_initiator_pkg;
    localparam int SGPIO_BITS_PER_DRV = 3;
    localparam int OFS_ACT = 0;
    localparam int OFS_LOC = 1;
    localparam int OFS_FAIL = 2;
    localparam int SGPIO_VENDOR_BITS = 4;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sgpio_initiator_if.sv
// sgpio_initiator_if: drive-status inputs, SGPIO pins and received-frame outputs of the initiator
interface sgpio_initiator_if #(parameter int NUM_DRV = 36);
    import sgpio_initiator_pkg::*;
    logic EN;
    logic [NUM_DRV-1:0] ACT, LOC, FAIL;
    logic SCLK_O, SLOAD_O, SDOUT_O, SDIN_I;
    logic [SGPIO_BITS_PER_DRV*NUM_DRV-1:0] IN_DATA;
    logic IN_VALID, FRAME_ST;
    modport master(input EN, ACT, LOC, FAIL, SDIN_I,
                   output SCLK_O, SLOAD_O, SDOUT_O, IN_DATA, IN_VALID, FRAME_ST);
    modport slave(output EN, ACT, LOC, FAIL, SDIN_I,
                  input SCLK_O, SLOAD_O, SDOUT_O, IN_DATA, IN_VALID, FRAME_ST);
endinterface

// File: rtl/sgpio_initiator_clk_gen.sv
// sgpio_initiator_clk_gen: SCLK half-period counter with fall/sample strobes, parked high while idle
module sgpio_initiator_clk_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic start,
    input  logic stop,
    output logic sclk_o,
    output logic fall_tick,
    output logic sample_tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    logic last, rise_tick;
    assign last = cnt == CW'(CLK_DIV - 1);
    assign rise_tick = !idle && !sclk_o && last;
    assign sample_tick = !idle && sclk_o && last;
    // a stop at the end of the high phase leaves SCLK high instead of falling
    assign fall_tick = start || (sample_tick && !stop);
    always_ff @(posedge clk) begin
        if (rst || (idle && !start)) begin
            cnt <= '0;
            sclk_o <= 1'b1;
        end else begin
            cnt <= (fall_tick || rise_tick || sample_tick) ? '0 : cnt + 1'b1;
            sclk_o <= !fall_tick && (rise_tick || sclk_o);
        end
    end
endmodule

// File: rtl/sgpio_initiator.sv
// sgpio_initiator: serialises per-drive ACT/LOC/FAIL onto SGPIO and deserialises the returning SDIN frame
module sgpio_initiator
    import sgpio_initiator_pkg::*;
#(
    parameter int NUM_DRV = 36,
    parameter int CLK_DIV = 125,
    parameter logic [SGPIO_VENDOR_BITS-1:0] VENDOR_L = '0
) (
    input logic SYSCLK,
    input logic RESET,
    sgpio_initiator_if.master bus
);
    localparam int F = SGPIO_BITS_PER_DRV * NUM_DRV;
    localparam int BW = $clog2(F);
    localparam logic [F-1:0] SLOAD_PAT = F'({VENDOR_L, 1'b1});
    state_t state, state_nx;
    logic [BW-1:0] bitc, bit_nx;
    logic [F-1:0] live, shadow, rx;
    logic [1:0] sync;
    logic start, last_bit, stop, fall_tick, sample_tick, new_frame;
    for (genvar i = 0; i < NUM_DRV; i++) begin : g_map
        assign live[SGPIO_BITS_PER_DRV*i+OFS_ACT] = bus.ACT[i];
        assign live[SGPIO_BITS_PER_DRV*i+OFS_LOC] = bus.LOC[i];
        assign live[SGPIO_BITS_PER_DRV*i+OFS_FAIL] = bus.FAIL[i];
    end
    assign start = state == IDLE && bus.EN;
    assign last_bit = bitc == BW'(F - 1);
    assign stop = last_bit && !bus.EN;
    assign new_frame = fall_tick && (state == IDLE || last_bit);
    sgpio_initiator_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk(SYSCLK),
        .rst(RESET),
        .idle(state == IDLE),
        .start(start),
        .stop(stop),
        .sclk_o(bus.SCLK_O),
        .fall_tick(fall_tick),
        .sample_tick(sample_tick)
    );
    always_comb begin
        state_nx = start ? RUN : (sample_tick && stop) ? IDLE : state;
        bit_nx = new_frame ? '0 : bitc + 1'b1;
    end
    always_ff @(posedge SYSCLK) begin
        if (RESET) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            bitc <= '0;
            shadow <= '0;
            rx <= '0;
            sync <= '0;
            bus.SLOAD_O <= 1'b0;
            bus.SDOUT_O <= 1'b0;
            bus.IN_DATA <= '0;
            bus.IN_VALID <= 1'b0;
            bus.FRAME_ST <= 1'b0;
        end else begin
            sync <= {sync[0], bus.SDIN_I};
            bus.FRAME_ST <= new_frame;
            bus.IN_VALID <= sample_tick && last_bit;
            if (new_frame) shadow <= live;
            // the shadow loads on this same edge, so bit 0 of a new frame comes from the live inputs
            if (fall_tick) begin
                bitc <= bit_nx;
                bus.SDOUT_O <= new_frame ? live[0] : shadow[bit_nx];
                bus.SLOAD_O <= SLOAD_PAT[bit_nx];
            end else if (sample_tick && stop) begin
                bitc <= '0;
                bus.SDOUT_O <= 1'b0;
                bus.SLOAD_O <= 1'b0;
            end
            if (sample_tick) rx[bitc] <= sync[1];
            if (sample_tick && last_bit) bus.IN_DATA <= {sync[1], rx[F-2:0]};
        end
    end
endmodule

// File: tb/tb_sgpio_initiator.sv
// tb_sgpio_initiator: directed checks of SGPIO framing, snapshot, loopback, EN drop and mid-frame reset
module tb_sgpio_initiator;
    logic clk, rst;
    int n_cmp = 0;
    int n_bad = 0;
    sgpio_initiator_if #(.NUM_DRV(4)) bus();
    sgpio_initiator #(.NUM_DRV(4), .CLK_DIV(4), .VENDOR_L(4'b1010)) dut (
        .SYSCLK(clk),
        .RESET(rst),
        .bus(bus)
    );
    assign bus.SDIN_I = bus.SDOUT_O;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        rst = 1'b1;
        bus.EN = 1'b0;
        bus.ACT = '0;
        bus.LOC = '0;
        bus.FAIL = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.SCLK_O !== 1'b1) begin n_bad++; $display("FAIL reset_sclk: got %b want 1", bus.SCLK_O); end
        n_cmp++; if (bus.SLOAD_O !== 1'b0) begin n_bad++; $display("FAIL reset_sload: got %b want 0", bus.SLOAD_O); end
        n_cmp++; if (bus.SDOUT_O !== 1'b0) begin n_bad++; $display("FAIL reset_sdout: got %b want 0", bus.SDOUT_O); end
        n_cmp++; if (bus.IN_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_in_valid: got %b want 0", bus.IN_VALID); end
        n_cmp++; if (bus.IN_DATA !== 12'h000) begin n_bad++; $display("FAIL reset_in_data: got %h want 000", bus.IN_DATA); end
        n_cmp++; if (bus.FRAME_ST !== 1'b0) begin n_bad++; $display("FAIL reset_frame_st: got %b want 0", bus.FRAME_ST); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame;
        logic [11:0] exp_sd, exp_sl;
        int k;
        exp_sd = 12'h801;
        exp_sl = 12'h015;
        bus.ACT = 4'b0001;
        bus.LOC = 4'b0000;
        bus.FAIL = 4'b1000;
        bus.EN = 1'b1;
        k = 0;
        while (!bus.FRAME_ST && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (k !== 1) begin n_bad++; $display("FAIL frame_start_latency: got %0d cycles want 1", k); end
        for (int n = 0; n < 12; n++) begin
            n_cmp++; if (bus.SCLK_O !== 1'b0) begin n_bad++; $display("FAIL frame_sclk_low bit%0d: got %b want 0", n, bus.SCLK_O); end
            n_cmp++; if (bus.SDOUT_O !== exp_sd[n]) begin n_bad++; $display("FAIL frame_sdout bit%0d: got %b want %b", n, bus.SDOUT_O, exp_sd[n]); end
            n_cmp++; if (bus.SLOAD_O !== exp_sl[n]) begin n_bad++; $display("FAIL frame_sload bit%0d: got %b want %b", n, bus.SLOAD_O, exp_sl[n]); end
            n_cmp++; if (bus.FRAME_ST !== (n == 0)) begin n_bad++; $display("FAIL frame_st bit%0d: got %b want %b", n, bus.FRAME_ST, n == 0); end
            repeat (4) @(negedge clk);
            n_cmp++; if (bus.SCLK_O !== 1'b1) begin n_bad++; $display("FAIL frame_sclk_high bit%0d: got %b want 1", n, bus.SCLK_O); end
            repeat (4) @(negedge clk);
        end
        n_cmp++; if (bus.FRAME_ST !== 1'b1) begin n_bad++; $display("FAIL frame_period: got FRAME_ST %b want 1 after 96 cycles", bus.FRAME_ST); end
        n_cmp++; if (bus.IN_VALID !== 1'b1) begin n_bad++; $display("FAIL frame_in_valid: got %b want 1", bus.IN_VALID); end
        n_cmp++; if (bus.IN_DATA !== 12'h801) begin n_bad++; $display("FAIL frame_in_data: got %h want 801", bus.IN_DATA); end
    endtask

    task automatic test_snapshot;
        logic [11:0] old_sd, new_sd;
        old_sd = 12'h801;
        new_sd = 12'hA49;
        repeat (40) @(negedge clk);
        bus.ACT = 4'b1111;
        for (int n = 5; n < 12; n++) begin
            n_cmp++; if (bus.SDOUT_O !== old_sd[n]) begin n_bad++; $display("FAIL snap_cur bit%0d: got %b want %b", n, bus.SDOUT_O, old_sd[n]); end
            repeat (8) @(negedge clk);
        end
        n_cmp++; if (bus.IN_DATA !== 12'h801) begin n_bad++; $display("FAIL snap_cur_in_data: got %h want 801", bus.IN_DATA); end
        for (int n = 0; n < 12; n++) begin
            n_cmp++; if (bus.SDOUT_O !== new_sd[n]) begin n_bad++; $display("FAIL snap_next bit%0d: got %b want %b", n, bus.SDOUT_O, new_sd[n]); end
            repeat (8) @(negedge clk);
        end
        n_cmp++; if (bus.IN_VALID !== 1'b1) begin n_bad++; $display("FAIL snap_next_in_valid: got %b want 1", bus.IN_VALID); end
        n_cmp++; if (bus.IN_DATA !== 12'hA49) begin n_bad++; $display("FAIL snap_next_in_data: got %h want a49", bus.IN_DATA); end
    endtask

    task automatic test_loopback;
        bus.ACT = 4'b0001;
        bus.LOC = 4'b0110;
        bus.FAIL = 4'b1000;
        repeat (96) @(negedge clk);
        n_cmp++; if (bus.IN_DATA !== 12'hA49) begin n_bad++; $display("FAIL loop_prev_in_data: got %h want a49", bus.IN_DATA); end
        repeat (96) @(negedge clk);
        n_cmp++; if (bus.IN_VALID !== 1'b1) begin n_bad++; $display("FAIL loop_in_valid: got %b want 1", bus.IN_VALID); end
        n_cmp++; if (bus.IN_DATA !== 12'h891) begin n_bad++; $display("FAIL loop_in_data: got %h want 891", bus.IN_DATA); end
        @(negedge clk);
        n_cmp++; if (bus.IN_VALID !== 1'b0) begin n_bad++; $display("FAIL loop_in_valid_pulse: got %b want 0", bus.IN_VALID); end
    endtask

    task automatic test_en_drop;
        int bad;
        repeat (23) @(negedge clk);
        n_cmp++; if (bus.SCLK_O !== 1'b0) begin n_bad++; $display("FAIL endrop_pos: got SCLK %b want 0 at bit 3", bus.SCLK_O); end
        bus.EN = 1'b0;
        repeat (64) @(negedge clk);
        n_cmp++; if (bus.SCLK_O !== 1'b0 || bus.SDOUT_O !== 1'b1) begin n_bad++; $display("FAIL endrop_last_bit: got SCLK %b SDOUT %b want 0 1", bus.SCLK_O, bus.SDOUT_O); end
        repeat (8) @(negedge clk);
        n_cmp++; if (bus.IN_VALID !== 1'b1) begin n_bad++; $display("FAIL endrop_in_valid: got %b want 1", bus.IN_VALID); end
        n_cmp++; if (bus.IN_DATA !== 12'h891) begin n_bad++; $display("FAIL endrop_in_data: got %h want 891", bus.IN_DATA); end
        n_cmp++; if (bus.FRAME_ST !== 1'b0) begin n_bad++; $display("FAIL endrop_frame_st: got %b want 0", bus.FRAME_ST); end
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.SCLK_O !== 1'b1 || bus.FRAME_ST !== 1'b0 || bus.SLOAD_O !== 1'b0 || bus.SDOUT_O !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL endrop_idle: got %0d non-idle cycles want 0", bad); end
    endtask

    task automatic test_reset_mid;
        int k, pulses;
        bus.EN = 1'b1;
        k = 0;
        while (!bus.FRAME_ST && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (bus.FRAME_ST !== 1'b1) begin n_bad++; $display("FAIL rmid_start: got FRAME_ST %b want 1 within 20 cycles", bus.FRAME_ST); end
        repeat (56) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.SCLK_O !== 1'b1 || bus.SLOAD_O !== 1'b0 || bus.SDOUT_O !== 1'b0) begin n_bad++; $display("FAIL rmid_pins: got SCLK %b SLOAD %b SDOUT %b want 1 0 0", bus.SCLK_O, bus.SLOAD_O, bus.SDOUT_O); end
        n_cmp++; if (bus.IN_DATA !== 12'h000 || bus.IN_VALID !== 1'b0) begin n_bad++; $display("FAIL rmid_rx: got IN_DATA %h IN_VALID %b want 000 0", bus.IN_DATA, bus.IN_VALID); end
        rst = 1'b0;
        k = 0;
        pulses = 0;
        while (!bus.FRAME_ST && k < 20) begin @(negedge clk); k++; if (bus.IN_VALID) pulses++; end
        n_cmp++; if (bus.FRAME_ST !== 1'b1 || bus.SDOUT_O !== 1'b1) begin n_bad++; $display("FAIL rmid_fresh: got FRAME_ST %b SDOUT %b want 1 1", bus.FRAME_ST, bus.SDOUT_O); end
        repeat (95) begin @(negedge clk); if (bus.IN_VALID) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rmid_no_valid: got %0d IN_VALID pulses want 0", pulses); end
        @(negedge clk);
        n_cmp++; if (bus.IN_VALID !== 1'b1 || bus.IN_DATA !== 12'h891) begin n_bad++; $display("FAIL rmid_frame_done: got IN_VALID %b IN_DATA %h want 1 891", bus.IN_VALID, bus.IN_DATA); end
        bus.EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_snapshot();
        test_loopback();
        test_en_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
